uart_fifo_bridge: RTL

Buffering stage between the UART CSR bank and `uart_core`. It holds CPU-written TX bytes in a TX FIFO and feeds them to the core's transmit handshake, one byte per `tx_ready` window. It also drains each byte the core receives into an RX FIFO and acknowledges it, so the CPU no longer has to service the core byte by byte. It connects directly to the core's `tx_data_i`/`data_write_en_i`/`tx_ready_o` and `rx_data_o`/`rx_ready_o`/`data_read_en_i` ports.

---
 rtl/uart_fifo_bridge_pkg.sv | 17 +
 rtl/uart_sfifo.sv | 83 ++++++++
 rtl/uart_fifo_bridge.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_fifo_bridge_pkg.sv
// Shared constants for the UART FIFO bridge: default FIFO size and the
// state encodings of the TX and RX handshake FSMs.
package uart_fifo_bridge_pkg;

  localparam int unsigned DEPTH_LOG2_DEFAULT = 4;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_WAIT = 1'b1
  } tx_state_e;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/uart_sfifo.sv
// Synchronous byte FIFO with registered level/full/empty and a registered
// show-ahead head. Storage is a plain circular buffer; pointers wrap modulo
// DEPTH. A push while full is accepted only alongside a pop.
module uart_sfifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  flush,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            head,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr, rd_ptr_inc;
  logic                  do_push, do_pop;
  logic [LW-1:0]         level_next;
  logic [7:0]            head_next;

  // Accept/reject decisions, next occupancy and next show-ahead head byte.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    do_pop     = pop && !empty && !flush;
    do_push    = push && (!full || do_pop) && !flush;
    rd_ptr_inc = rd_ptr + DEPTH_LOG2'(1);
    level_next = level;
    head_next  = head;
    if (do_push && !do_pop)      level_next = level + LW'(1);
    else if (do_pop && !do_push) level_next = level - LW'(1);
    if (do_pop) begin
      // With one entry left, the byte written this cycle becomes the head.
      head_next = (do_push && wr_ptr == rd_ptr_inc) ? push_data : mem[rd_ptr_inc];
    end else if (empty && do_push) begin
      head_next = push_data;
    end
  end

  // Storage write port.
  // NOTE: the data array has no reset; only pointers and status are reset,
  // which keeps it mappable to plain RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy, status flags and head register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr_inc;
      level <= level_next;
      full  <= (level_next == DEPTH_LVL);
      empty <= (level_next == '0);
      head  <= head_next;
    end
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Buffers CPU TX bytes toward uart_core and drains received bytes from the
// core into an RX FIFO. Two small handshake FSMs drive the core strobes; all
// outputs are registered. Sticky error flags report dropped bytes.
module uart_fifo_bridge
  import uart_fifo_bridge_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  rst_soft_i,
  input  logic                  cpu_tx_push_i,
  input  logic [7:0]            cpu_tx_data_i,
  input  logic                  cpu_rx_pop_i,
  output logic [7:0]            cpu_rx_data_o,
  input  logic                  cpu_clr_err_i,
  output logic [DEPTH_LOG2:0]   tx_level_o,
  output logic [DEPTH_LOG2:0]   rx_level_o,
  output logic                  tx_full_o,
  output logic                  rx_empty_o,
  output logic                  tx_overflow_o,
  output logic                  rx_overrun_o,
  input  logic                  core_tx_ready_i,
  output logic [7:0]            core_tx_data_o,
  output logic                  core_data_write_en_o,
  input  logic                  core_rx_ready_i,
  input  logic [7:0]            core_rx_data_i,
  output logic                  core_data_read_en_o
);

  tx_state_e  tx_state, tx_state_next;
  rx_state_e  rx_state, rx_state_next;
  logic [7:0] tx_head;
  logic       tx_empty, rx_full;
  logic       tx_issue, rx_accept;
  logic       tx_overflow_set, rx_overrun_set;

  uart_sfifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .flush     (rst_soft_i),
    .push      (cpu_tx_push_i),
    .push_data (cpu_tx_data_i),
    .pop       (tx_issue),
    .head      (tx_head),
    .level     (tx_level_o),
    .full      (tx_full_o),
    .empty     (tx_empty)
  );

  uart_sfifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .flush     (rst_soft_i),
    .push      (rx_accept),
    .push_data (core_rx_data_i),
    .pop       (cpu_rx_pop_i),
    .head      (cpu_rx_data_o),
    .level     (rx_level_o),
    .full      (rx_full),
    .empty     (rx_empty_o)
  );

  // TX FSM: state register plus the registered strobe and data toward the core.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tx_state             <= TX_IDLE;
      core_data_write_en_o <= 1'b0;
      core_tx_data_o       <= '0;
    end else if (rst_soft_i) begin
      tx_state             <= TX_IDLE;
      core_data_write_en_o <= 1'b0;
      core_tx_data_o       <= '0;
    end else begin
      tx_state             <= tx_state_next;
      core_data_write_en_o <= tx_issue;
      if (tx_issue) core_tx_data_o <= tx_head;
    end
  end

  // TX FSM next state: wait in TX_WAIT until the core drops ready.
  always_comb begin
    tx_state_next = tx_state;
    case (tx_state)
      TX_IDLE: if (core_tx_ready_i && !tx_empty) tx_state_next = TX_WAIT;
      TX_WAIT: if (!core_tx_ready_i)             tx_state_next = TX_IDLE;
      default:                                   tx_state_next = TX_IDLE;
    endcase
  end

  // TX FSM outputs: issue (pop + strobe) one byte per ready window.
  always_comb begin
    tx_issue = (tx_state == TX_IDLE) && core_tx_ready_i && !tx_empty && !rst_soft_i;
  end

  // RX FSM: state register plus the registered acknowledge strobe.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rx_state            <= RX_IDLE;
      core_data_read_en_o <= 1'b0;
    end else if (rst_soft_i) begin
      rx_state            <= RX_IDLE;
      core_data_read_en_o <= 1'b0;
    end else begin
      rx_state            <= rx_state_next;
      core_data_read_en_o <= rx_accept;
    end
  end

  // RX FSM next state: one cycle in RX_ACK while the core clears ready.
  always_comb begin
    rx_state_next = rx_state;
    case (rx_state)
      RX_IDLE: if (core_rx_ready_i) rx_state_next = RX_ACK;
      RX_ACK:                       rx_state_next = RX_IDLE;
      default:                      rx_state_next = RX_IDLE;
    endcase
  end

  // RX FSM outputs: take the byte (even if it will be dropped) and ack it.
  always_comb begin
    rx_accept = (rx_state == RX_IDLE) && core_rx_ready_i && !rst_soft_i;
  end

  // Error detection: a byte is dropped when its FIFO is full and nothing leaves.
  always_comb begin
    tx_overflow_set = cpu_tx_push_i && tx_full_o && !tx_issue && !rst_soft_i;
    rx_overrun_set  = rx_accept && rx_full && !cpu_rx_pop_i;
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tx_overflow_o <= 1'b0;
      rx_overrun_o  <= 1'b0;
    end else if (rst_soft_i) begin
      tx_overflow_o <= 1'b0;
      rx_overrun_o  <= 1'b0;
    end else begin
      tx_overflow_o <= tx_overflow_set || (tx_overflow_o && !cpu_clr_err_i);
      rx_overrun_o  <= rx_overrun_set  || (rx_overrun_o  && !cpu_clr_err_i);
    end
  end

endmodule
